// File: rtl/inst_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared constants for the SRAM-style port responder: default
//               base address, word width and clear/ready state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

  localparam logic [31:0] c_base_addr = 32'h1c00_0000;
  localparam int          c_word_w    = 32;

  // Responder FSM encodings
  localparam logic [0:0]  RSP_CLEAR   = 1'b0;
  localparam logic [0:0]  RSP_READY   = 1'b1;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/inst_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_responder_if
// Description : Single-cycle SRAM-style port bundle. The master modport is the
//               pipeline-stage initiator; the slave modport is the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_sram_responder_if;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        busy;
  logic        addr_err;

  modport master (
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata, busy, addr_err
  );

  modport slave (
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata, busy, addr_err
  );

endinterface : inst_sram_responder_if
`default_nettype wire

// File: rtl/inst_sram_responder_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : byte_merge
// Description : Combinational byte-lane merge. Each byte with its enable set
//               takes the new data; the rest keep the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_merge (
  input  wire logic [31:0] i_old_word,
  input  wire logic [31:0] i_wdata,
  input  wire logic [3:0]  i_we,
  output logic      [31:0] o_merged
);

  // One mux per byte lane
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign o_merged[8*gi +: 8] = i_we[gi] ? i_wdata[8*gi +: 8]
                                            : i_old_word[8*gi +: 8];
    end
  endgenerate

endmodule : byte_merge
`default_nettype wire

// File: rtl/inst_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_responder
// Description : Responder for the single-cycle SRAM fetch/data port. Word
//               memory with 1-cycle read latency, byte-masked write-first
//               writes, rdata hold while idle, and an optional post-reset
//               sequential clear flagged by busy.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sram_responder
  import cpu_defs::*;
#(
  parameter int          DEPTH          = 1024,
  parameter logic [31:0] BASE_ADDR      = c_base_addr,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  wire logic            clk,
  input  wire logic            resetn,   // active-high, synchronous
  inst_sram_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [c_word_w-1:0] r_mem [DEPTH];
  logic [0:0]          r_state;
  logic [AW-1:0]       r_clr_idx;
  logic [31:0]         r_rdata;
  logic                r_addr_err;
  logic                r_busy;

  logic [31:0]         w_off;
  logic [31:0]         w_word;
  logic                w_in_range;
  logic [AW-1:0]       w_idx;
  logic                w_accept;
  logic                w_is_write;
  logic [31:0]         w_old;
  logic [31:0]         w_merged;

  // Offset wraps modulo 2^32, so addresses below the base land far out of range
  assign w_off      = bus.sram_addr - BASE_ADDR;
  assign w_word     = w_off >> 2;
  assign w_in_range = (w_word < 32'(DEPTH));
  assign w_idx      = w_word[AW-1:0];
  assign w_accept   = bus.sram_en && (r_state == RSP_READY);
  assign w_is_write = (bus.sram_we != 4'b0000);
  assign w_old      = r_mem[w_idx];

  byte_merge u_byte_merge (
    .i_old_word (w_old),
    .i_wdata    (bus.sram_wdata),
    .i_we       (bus.sram_we),
    .o_merged   (w_merged)
  );

  // Memory array: clear sweep or accepted in-range write; reset leaves contents alone
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (r_state == RSP_CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_accept && w_in_range && w_is_write) begin
        r_mem[w_idx] <= w_merged;
      end
    end
  end

  // Clear/ready FSM with registered rdata, addr_err and busy
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state    <= CLEAR_ON_RESET ? RSP_CLEAR : RSP_READY;
      r_busy     <= CLEAR_ON_RESET;
      r_clr_idx  <= '0;
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      case (r_state)
        RSP_CLEAR: begin
          // Requests are dropped here; rdata simply holds
          if (r_clr_idx == AW'(DEPTH - 1)) begin
            r_state <= RSP_READY;
            r_busy  <= 1'b0;
          end
          r_clr_idx <= r_clr_idx + 1'b1;
        end
        default: begin
          if (w_accept) begin
            if (w_in_range) begin
              // Write-first: a write returns the merged word
              r_rdata <= w_is_write ? w_merged : w_old;
            end else begin
              r_rdata    <= '0;
              r_addr_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.sram_rdata = r_rdata;
  assign bus.addr_err   = r_addr_err;
  assign bus.busy       = r_busy;

endmodule : inst_sram_responder
`default_nettype wire

// File: tb/tb_inst_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sram_responder
// Description : Scoreboard bench for inst_sram_responder. A driver issues
//               directed and random requests and pushes the reference model's
//               expected outputs; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sram_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1c00_0000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_sram_responder_if bus ();

  inst_sram_responder #(
    .DEPTH          (DEPTH),
    .BASE_ADDR      (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [31:0] mmem [int];
  int          clr_left = 0;
  logic [31:0] m_rdata  = '0;
  logic        m_err    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input int idx);
    return mmem.exists(idx) ? mmem[idx] : 32'h0;
  endfunction

  // Behavioural model of one clock edge
  task automatic mstep(input logic rst, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    logic [31:0] w;
    int          idx;
    if (rst) begin
      m_rdata  = '0;
      m_err    = 1'b0;
      mmem.delete();          // clear ends with all words zero
      clr_left = DEPTH;
    end else if (clr_left > 0) begin
      clr_left--;
      m_err = 1'b0;
    end else if (en) begin
      off = addr - BASE;
      if ((off >> 2) < DEPTH) begin
        idx = int'(off >> 2);
        w   = mread(idx);
        for (int b = 0; b < 4; b++)
          if (we[b]) w[8*b +: 8] = wdata[8*b +: 8];
        if (we != 4'b0) mmem[idx] = w;
        m_rdata = w;
        m_err   = 1'b0;
      end else begin
        m_rdata = '0;
        m_err   = 1'b1;
      end
    end else begin
      m_err = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus and record what should appear after the edge
  task automatic cycle(input logic rst, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    @(negedge clk);
    resetn         = rst;
    bus.sram_en    = en;
    bus.sram_we    = we;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    mstep(rst, en, we, addr, wdata);
    e.rdata = m_rdata;
    e.err   = m_err;
    e.busy  = (clr_left > 0);
    q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] addr);
    cycle(1'b0, 1'b1, 4'b0, addr, $urandom);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] d);
    cycle(1'b0, 1'b1, we, addr, d);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  // Directed constant check right after the edge of the last driven cycle
  task automatic expect_now(input string name, input logic [31:0] rdata, input logic err);
    @(posedge clk);
    #2;
    check({name, "_rdata"}, bus.sram_rdata, rdata);
    check({name, "_err"}, 32'(bus.addr_err), 32'(err));
  endtask

  // Reset for two cycles, then count busy cycles while reading; optional early abort
  task automatic reset_and_count(input int abort_at, output int cnt);
    cycle(1'b1, 1'b1, 4'b0, BASE, '0);
    cycle(1'b1, 1'b0, 4'b0, BASE, '0);
    @(posedge clk);
    #2;
    cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 2000; i++) begin
      if (cnt == abort_at) break;
      rd(BASE + 32'(4 * $urandom_range(0, 15)));
      @(posedge clk);
      #2;
      if (bus.busy) cnt++;
      else break;
    end
  endtask

  // Monitor: every cycle compare DUT outputs with the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_rdata", bus.sram_rdata, e.rdata);
        check("sb_addr_err", 32'(bus.addr_err), 32'(e.err));
        check("sb_busy", 32'(bus.busy), 32'(e.busy));
      end
    end
  end

  // Driver
  initial begin
    int cnt;
    logic [31:0] a;
    resetn         = 1'b1;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;

    // Clear length with reads during clear
    reset_and_count(-1, cnt);
    check("busy_len", 32'(cnt), 32'(DEPTH));
    rd(32'h1c00_0ffc);
    expect_now("last_word_zero", 32'h0, 1'b0);

    // Write then masked write
    wr(32'h1c00_0010, 4'hf, 32'hdead_beef);
    expect_now("wr_full", 32'hdead_beef, 1'b0);
    wr(32'h1c00_0010, 4'b0010, 32'h0000_5500);
    expect_now("wr_masked", 32'hdead_55ef, 1'b0);

    // Hold while idle
    rd(32'h1c00_0010);
    for (int i = 0; i < 5; i++) idle();
    expect_now("hold", 32'hdead_55ef, 1'b0);

    // Out of range above and below, memory untouched
    wr(32'h1c00_1000, 4'hf, 32'h1234_5678);
    expect_now("oor_high", 32'h0, 1'b1);
    idle();
    expect_now("oor_pulse_end", 32'h0, 1'b0);
    rd(32'h1bff_fffc);
    expect_now("oor_low", 32'h0, 1'b1);
    rd(32'h1c00_0010);
    expect_now("after_oor", 32'hdead_55ef, 1'b0);

    // Streaming reads
    wr(BASE + 0, 4'hf, 32'd1);
    wr(BASE + 4, 4'hf, 32'd2);
    wr(BASE + 8, 4'hf, 32'd3);
    rd(BASE + 0);
    expect_now("stream0", 32'd1, 1'b0);
    rd(BASE + 4);
    expect_now("stream1", 32'd2, 1'b0);
    rd(BASE + 8);
    expect_now("stream2", 32'd3, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
        1: a = $urandom;
        2: a = BASE + 32'((DEPTH - 1) * 4);
        default: ;
      endcase
      cycle(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0,
            a, $urandom);
    end

    // Reset in the middle of a clear restarts it from the beginning
    reset_and_count(500, cnt);
    check("abort_point", 32'(cnt), 32'd500);
    reset_and_count(-1, cnt);
    check("busy_len_restart", 32'(cnt), 32'(DEPTH));
    rd(32'h1c00_0010);
    expect_now("cleared_after_restart", 32'h0, 1'b0);

    idle();
    @(posedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_sram_responder
`default_nettype wire

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Responder end of the single-cycle SRAM-style fetch/data port (en, we, addr, wdata → rdata) that pipeline stages drive as initiators.
- Holds a word-organised backing memory with 1-cycle read latency, byte-masked writes and write-first read-during-write.
- Keeps rdata stable while en is low, which the fetch stage relies on when it stalls.
- Optionally clears memory after reset with a sequential clear FSM, flagged by busy; used as the bench/simulation memory behind IF and MEM stages.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h1c000000: byte address mapped to word 0.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset (busy asserted); 0 = contents untouched by reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-high reset: resetn==1 at a rising edge performs reset.
- sram_en  in  1  request valid this cycle.
- sram_we  in  4  byte write enables; 4'b0 means read.
- sram_addr  in  32  byte address; bits [1:0] ignored.
- sram_wdata  in  32  write data; byte i = bits [8i+7:8i].
- sram_rdata  out  32  read data, valid the cycle after an accepted request.
- busy  out  1  clear in progress; requests ignored.
- addr_err  out  1  one-cycle pulse, the cycle after an accepted out-of-range request.

Behaviour:
- Reset values:
  - sram_rdata = 0, addr_err = 0.
  - FSM → CLEAR with clear index 0 if CLEAR_ON_RESET, else → READY.
  - busy = 1 during CLEAR, 0 in READY.
- Reset mid-CLEAR restarts the clear at index 0. Reset has priority over every other event.
- FSM states and transitions:
  - CLEAR: writes 0 to word[idx] each cycle and increments idx; moves to READY after writing word DEPTH-1, taking exactly DEPTH cycles.
  - READY: terminal state until the next reset.
- Accepted request: sram_en=1, state READY, resetn=0. Requests during CLEAR are dropped, with no memory effect and no rdata change.
- Word index: off = sram_addr - BASE_ADDR, computed with 32-bit unsigned wrap-around. In range iff off[31:2] < DEPTH; idx = off[31:2].
- Write (we≠0, in range): each byte i with we[i]=1 is replaced by wdata byte i; the other bytes are kept.
- Read latency is 1:
  - An accepted request at edge N loads sram_rdata at edge N with the word value after that edge's write (write-first).
  - A masked write therefore returns the merged word.
  - Applies to both read and write requests.
- Out-of-range accepted request: no write, sram_rdata ← 0, addr_err = 1 for exactly one cycle.
- Hold: if no accepted request, sram_rdata keeps its previous value and addr_err = 0.
- Back-to-back requests every cycle are supported at full throughput; there is no backpressure signal.
- Memory contents and sram_rdata are never X after a CLEAR_ON_RESET=1 reset.

Decomposition:
- Shared package (cpu_defs): BASE_ADDR default constant, the word-width constant 32, and FSM state encodings RSP_CLEAR/RSP_READY as localparams.
- One natural sub-module, byte_merge: combinational old-word/wdata/we → merged word, reusable by the data-SRAM side.
- The memory array and FSM stay in the top module.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=1024, and drive reads during clear:
  - busy stays high exactly 1024 cycles, then 0.
  - Reads during clear leave rdata = 0.
  - Reading 0x1c000ffc afterwards returns 0.
- Write-then-read:
  - Write 0x1c000010 we=4'hf wdata=0xdeadbeef → next-cycle rdata = 0xdeadbeef.
  - Then we=4'b0010 wdata=0x00005500 → rdata = 0xdead55ef.
- Hold: read 0x1c000010, then en=0 for 5 cycles → rdata stays 0xdead55ef.
- Out of range: read 0x1c001000 and 0x1bfffffc → rdata = 0, addr_err pulses 1 cycle each, memory unchanged.
- Streaming: consecutive reads 0x1c000000, 0x1c000004, 0x1c000008 preloaded with 1, 2, 3 → rdata sequence 1, 2, 3 on successive cycles.
- Reset mid-clear: assert resetn=1 at clear cycle 500 → busy lasts a further full 1024 cycles after reset deasserts.
